// File: rtl/ram16b_fifo_pkg.sv
// Shared definitions for the ram16b FIFO controller: default widths, output-buffer
// occupancy encoding and the read-issue credit helper.
package ram16b_fifo_pkg;

  localparam int unsigned FIFO_DW = 16;
  localparam int unsigned FIFO_AW = 5;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // A read may start only if the head/skid pair can still absorb it when it returns.
  function automatic logic issue_credit(input logic [1:0] occ, input logic inflight,
                                        input logic pop);
    logic [2:0] used;
    used = {1'b0, occ} + {2'b00, inflight};
    return used < (3'd2 + {2'b00, pop});
  endfunction

endpackage

// File: rtl/ram16b_fifo_outbuf.sv
// Two-entry head/skid buffer that absorbs the RAM read latency and presents a
// first-word-fall-through head to the consumer.
module ram16b_fifo_outbuf
  import ram16b_fifo_pkg::*;
#(
  parameter int unsigned DW = FIFO_DW
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          flush_i,
  input  logic          cap_valid_i,
  input  logic [DW-1:0] cap_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  output logic [1:0]    occ_o
);

  occ_e          occ_q, occ_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          valid_q, valid_d;

  // Buffer state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      occ_q   <= OCC_EMPTY;
      head_q  <= {DW{1'b0}};
      skid_q  <= {DW{1'b0}};
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
    end
  end

  // Capture/pop/flush next-state; pop_i is only asserted while the head is valid.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush_i) begin
      occ_d = OCC_EMPTY;
    end else begin
      case ({pop_i, cap_valid_i})
        2'b11: begin
          if (occ_q == OCC_TWO) begin
            head_d = skid_q;
            skid_d = cap_data_i;
          end else begin
            head_d = cap_data_i;
          end
        end
        2'b10: begin
          head_d = skid_q;
          occ_d  = (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
        end
        2'b01: begin
          if (occ_q == OCC_EMPTY) begin
            head_d = cap_data_i;
            occ_d  = OCC_ONE;
          end else begin
            skid_d = cap_data_i;
            occ_d  = OCC_TWO;
          end
        end
        default: begin
          occ_d = occ_q;
        end
      endcase
    end
    valid_d = (occ_d != OCC_EMPTY);
  end

  assign out_data_o  = head_q;
  assign out_valid_o = valid_q;
  assign occ_o       = occ_q;

endmodule

// File: rtl/ram16b_fifo_ctl.sv
// FIFO controller driving an external 32x16 ram16b with FWFT output.
// Optional RAM16B_FIFO_BYPASS_EN: pushes into a fully empty FIFO go straight to the head.
module ram16b_fifo_ctl
  import ram16b_fifo_pkg::*;
#(
  parameter int unsigned DW = FIFO_DW,
  parameter int unsigned AW = FIFO_AW
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          flush_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW:0]   level_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic          ram_wen_o,
  output logic [AW-1:0] ram_waddr_o,
  output logic [AW-1:0] ram_raddr_o,
  input  logic [DW-1:0] ram_rdata_i
);

  localparam logic [AW:0] RAM_DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          inflight_q, inflight_d;
  logic [AW:0]   level_q, level_d;

  logic [AW:0]   ram_cnt_s;
  logic          ram_full_s, ram_empty_s;
  logic          push_s, pop_s, bypass_s, ram_push_s, issue_s;
  logic          cap_valid_s;
  logic [DW-1:0] cap_data_s;
  logic [1:0]    occ_s;

  assign ram_cnt_s   = wr_ptr_q - rd_ptr_q;
  assign ram_full_s  = (ram_cnt_s == RAM_DEPTH);
  assign ram_empty_s = (wr_ptr_q == rd_ptr_q);
  assign in_ready_o  = reset_ni & ~ram_full_s & ~flush_i;
  assign push_s      = in_valid_i & in_ready_o;
  assign pop_s       = out_valid_o & out_ready_i;

  // Bypass only when no older word exists in RAM, in flight, or in the buffer.
  always_comb begin
`ifdef RAM16B_FIFO_BYPASS_EN
    bypass_s = push_s & ram_empty_s & ~inflight_q &
               ((occ_s == OCC_EMPTY) | ((occ_s == OCC_ONE) & pop_s));
`else
    bypass_s = 1'b0;
`endif
  end

  assign ram_push_s  = push_s & ~bypass_s;
  assign issue_s     = ~ram_empty_s & issue_credit(occ_s, inflight_q, pop_s) & ~flush_i;
  assign cap_valid_s = (inflight_q & ~flush_i) | bypass_s;
  assign cap_data_s  = inflight_q ? ram_rdata_i : in_data_i;

  // Pointer, in-flight and level register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q   <= {(AW+1){1'b0}};
      rd_ptr_q   <= {(AW+1){1'b0}};
      inflight_q <= 1'b0;
      level_q    <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
    end
  end

  // Next-state: flush drops everything still queued; level tracks accepted minus popped.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = 1'b0;
    level_d    = level_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = {(AW+1){1'b0}};
    end else begin
      if (ram_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (issue_s) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        inflight_d = 1'b1;
      end else begin
        rd_ptr_d   = rd_ptr_q;
        inflight_d = 1'b0;
      end
      level_d = level_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end
  end

  assign ram_wen_o   = ram_push_s;
  assign ram_waddr_o = wr_ptr_q[AW-1:0];
  assign ram_wdata_o = in_data_i;
  assign ram_raddr_o = rd_ptr_q[AW-1:0];
  assign level_o     = level_q;

  ram16b_fifo_outbuf #(
    .DW(DW)
  ) u_outbuf (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .flush_i    (flush_i),
    .cap_valid_i(cap_valid_s),
    .cap_data_i (cap_data_s),
    .pop_i      (pop_s),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .occ_o      (occ_s)
  );

endmodule

// File: tb/tb_ram16b_fifo_ctl.sv
// Bench for ram16b_fifo_ctl paired with a behavioural 32x16 registered-read RAM;
// a queue model checks every cycle, directed phases pin literal values.
module tb_ram16b_fifo_ctl;

  localparam int DW = 16;
  localparam int AW = 5;
`ifdef RAM16B_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   level;
  logic [DW-1:0] ram_wdata;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  ram16b_fifo_ctl dut (
    .clk_i      (clk),
    .reset_ni   (rst_n),
    .flush_i    (flush),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .level_o    (level),
    .ram_wdata_o(ram_wdata),
    .ram_wen_o  (ram_wen),
    .ram_waddr_o(ram_waddr),
    .ram_raddr_o(ram_raddr),
    .ram_rdata_i(ram_rdata)
  );

  // ram16b stand-in: synchronous write, registered read address.
  logic [DW-1:0] ram_mem [0:31];
  always @(posedge clk) begin
    if (ram_wen) ram_mem[ram_waddr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_raddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;
  ent_t mq[$];
  int   cyc = 0;

  // Reference queue: outputs checked against it every cycle, then this cycle's handshakes applied.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
      end else begin
        chk("level", 32'(level), 32'(mq.size()));
        if (out_valid) begin
          chk("valid_needs_entry", 32'(mq.size() != 0), 32'd1);
          if (mq.size() != 0) chk("head_data", 32'(out_data), 32'(mq[0].d));
        end
        if (mq.size() != 0 && cyc >= mq[0].t + 3) chk("head_latency", 32'(out_valid), 32'd1);
        if (flush) chk("ready_flush", 32'(in_ready), 32'd0);
        else if (mq.size() <= 31) chk("ready_room", 32'(in_ready), 32'd1);
        else if (mq.size() == 34) chk("ready_full", 32'(in_ready), 32'd0);
`ifdef RAM16B_FIFO_BYPASS_EN
        if (ram_wen) chk("wen_handshake", 32'(in_valid & in_ready), 32'd1);
`else
        chk("wen_handshake", 32'(ram_wen), 32'(in_valid & in_ready));
`endif
        if (ram_wen) chk("wdata", 32'(ram_wdata), 32'(in_data));
        if (flush) begin
          mq.delete();
        end else begin
          if (out_valid && out_ready && mq.size() != 0) void'(mq.pop_front());
          if (in_valid && in_ready) mq.push_back('{d: in_data, t: cyc});
        end
      end
      cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int got;
    int gaps;
    int pushed;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_wen", 32'(ram_wen), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Single word round trip.
    next_cycle();
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 32'(k == LAT));
      if (k == LAT) chk("t1_data", 32'(out_data), 32'h1234);
      chk("t1_level", 32'(level), (k <= LAT) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // Fill to 34 with the consumer stalled, then drain.
    out_ready = 1'b0; acc = 0; in_valid = 1'b1;
    for (int c = 0; c < 45; c++) begin
      in_data = 16'(acc);
      @(negedge clk);
      if (in_ready) acc++;
      next_cycle();
    end
    in_valid = 1'b0;
    chk("t2_accepted", 32'(acc), 32'd34);
    @(negedge clk);
    chk("t2_level_full", 32'(level), 32'd34);
    chk("t2_ready_full", 32'(in_ready), 32'd0);
    next_cycle();
    out_ready = 1'b1; got = 0;
    for (int c = 0; c < 80 && got < 34; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("t2_order", 32'(out_data), 32'(got));
        got++;
      end
      next_cycle();
    end
    chk("t2_popped", 32'(got), 32'd34);
    @(negedge clk);
    chk("t2_level_empty", 32'(level), 32'd0);
    next_cycle();

    // Streaming: 100 words, one per cycle once the pipe is primed.
    pushed = 0; got = 0; gaps = 0;
    for (int c = 0; c < 200 && got < 100; c++) begin
      in_valid = (pushed < 100);
      in_data  = 16'(16'h1000 + pushed);
      @(negedge clk);
      if (in_valid && in_ready) pushed++;
      if (out_valid) begin
        chk("t3_order", 32'(out_data), 32'(16'h1000 + got));
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      next_cycle();
    end
    in_valid = 1'b0;
    chk("t3_count", 32'(got), 32'd100);
    chk("t3_gaps", 32'(gaps), 32'd0);

    // Flush with 10 queued and a read in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h2000 + i);
      next_cycle();
    end
    in_valid = 1'b0;
    repeat (5) next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_pop_head", 32'(out_data), 32'h2000);
    next_cycle();
    out_ready = 1'b0; flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_level", 32'(level), 32'd0);
    next_cycle();
    in_valid = 1'b1; in_data = 16'hBEEF;
    next_cycle();
    in_valid = 1'b0; out_ready = 1'b1; got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("t4_after_flush", 32'(out_data), 32'hBEEF);
        got++;
      end
      next_cycle();
    end
    chk("t4_seen", 32'(got), 32'd1);

    // Asynchronous reset in the middle of a stream.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h3000 + i);
      next_cycle();
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_wen", 32'(ram_wen), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    next_cycle();
    in_valid = 1'b1; in_data = 16'hA5A5;
    next_cycle();
    in_valid = 1'b0; out_ready = 1'b1; got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("t5_roundtrip", 32'(out_data), 32'hA5A5);
        got++;
      end
      next_cycle();
    end
    chk("t5_seen", 32'(got), 32'd1);

    // Random traffic checked by the reference queue.
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = (c < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      next_cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (60) next_cycle();
    @(negedge clk);
    chk("t6_drained", 32'(level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
